// File: rtl/lemmings_pkg.sv
// Shared definitions for the Lemmings walker environment: terrain FSM state
// encoding and the default parameter set used by the terrain model and benches.
package lemmings_pkg;

  typedef enum logic [1:0] {
    ST_WALK = 2'd0,
    ST_FALL = 2'd1,
    ST_DEAD = 2'd2
  } lem_state_e;

  localparam int unsigned DEF_WIDTH       = 16;
  localparam int unsigned DEF_POS_W       = 4;
  localparam int unsigned DEF_START_POS   = 4;
  localparam int unsigned DEF_STEP_CYCLES = 2;
  localparam int unsigned DEF_HOLE_DEPTH  = 12;
  localparam int unsigned DEF_DIG_CYCLES  = 4;
  localparam int unsigned DEF_DIG_DEPTH   = 3;

endpackage

// File: rtl/lemmings_step_tick.sv
// Walking step divider: counts 0..STEP_CYCLES-1 while enabled and flags the
// wrap cycle.
// Ports:
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   clr                : synchronous counter clear (wins over en)
//   en                 : count enable
//   tick_c             : combinational, high in the cycle the counter wraps
module lemmings_step_tick #(
  parameter int unsigned STEP_CYCLES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = en && !clr && (cnt_q == CNT_W'(STEP_CYCLES - 1));

  // Step counter
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lemmings_terrain.sv
// Terrain/environment model for the walking lemming. Holds a 1-D ground map,
// tracks position and fall depth, and closes the loop with the walker by
// turning its walk/aaah/digging outputs into bump/ground/dig inputs.
// Ports:
//   sys_clk, sys_rst_n          : clock, synchronous active-low reset
//   map_load, map_in            : load a ground bitmap (1 = solid, 0 = hole)
//   dig_req                     : player dig command
//   walk_left, walk_right,
//   aaah, digging               : walker outputs
//   bump_left, bump_right       : wall-bump pulses to the walker
//   ground                      : ground present under the lemming
//   dig                         : dig command to the walker
//   pos                         : current cell
//   dead                        : sticky splat indicator
module lemmings_terrain
  import lemmings_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned POS_W       = DEF_POS_W,
  parameter int unsigned START_POS   = DEF_START_POS,
  parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int unsigned HOLE_DEPTH  = DEF_HOLE_DEPTH,
  parameter int unsigned DIG_CYCLES  = DEF_DIG_CYCLES,
  parameter int unsigned DIG_DEPTH   = DEF_DIG_DEPTH
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             map_load,
  input  logic [WIDTH-1:0] map_in,
  input  logic             dig_req,
  input  logic             walk_left,
  input  logic             walk_right,
  input  logic             aaah,
  input  logic             digging,
  output logic             bump_left,
  output logic             bump_right,
  output logic             ground,
  output logic             dig,
  output logic [POS_W-1:0] pos,
  output logic             dead
);

  localparam int unsigned FALL_MAX  = (HOLE_DEPTH > DIG_DEPTH) ? HOLE_DEPTH : DIG_DEPTH;
  localparam int unsigned FALL_W    = $clog2(FALL_MAX + 1);
  localparam int unsigned DIG_CNT_W = $clog2(DIG_CYCLES + 1);

  lem_state_e           state_q, state_d;
  logic [WIDTH-1:0]     map_q, map_d;
  logic [FALL_W-1:0]    fall_cnt_q, fall_cnt_d;
  logic [FALL_W-1:0]    fall_len_q, fall_len_d;
  logic [DIG_CNT_W-1:0] dig_cnt_q, dig_cnt_d;
  logic                 idle_q, idle_d;
  logic [POS_W-1:0]     pos_d;
  logic                 ground_d, bump_l_d, bump_r_d, dig_d, dead_d;
  logic                 step_en, step_tick_c;

  // Steps only advance while walking on solid ground and not digging
  assign step_en = (state_q == ST_WALK) && (walk_left || walk_right) && !digging;

  lemmings_step_tick #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_tick (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (!step_en),
    .en       (step_en),
    .tick_c   (step_tick_c)
  );

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    map_d      = map_q;
    fall_cnt_d = fall_cnt_q;
    fall_len_d = fall_len_q;
    dig_cnt_d  = dig_cnt_q;
    idle_d     = 1'b0;
    pos_d      = pos;
    ground_d   = ground;
    bump_l_d   = 1'b0;
    bump_r_d   = 1'b0;
    dead_d     = dead;

    case (state_q)
      ST_WALK: begin
        if (digging) begin
          // Breakthrough on the edge that closes the DIG_CYCLES-th digging cycle
          if (dig_cnt_q == DIG_CNT_W'(DIG_CYCLES - 1)) begin
            map_d[pos] = 1'b0;
            ground_d   = 1'b0;
            fall_len_d = FALL_W'(DIG_DEPTH);
            fall_cnt_d = '0;
            dig_cnt_d  = '0;
            state_d    = ST_FALL;
          end else begin
            dig_cnt_d = dig_cnt_q + DIG_CNT_W'(1);
          end
        end else begin
          dig_cnt_d = '0;
          // Both directions at once is illegal from the walker: no move, no bump
          if (step_tick_c && walk_right && !walk_left) begin
            if (pos == POS_W'(WIDTH - 1)) bump_r_d = 1'b1;
            else                          pos_d    = pos + POS_W'(1);
          end else if (step_tick_c && walk_left && !walk_right) begin
            if (pos == '0) bump_l_d = 1'b1;
            else           pos_d    = pos - POS_W'(1);
          end
          if ((pos_d != pos) && !map_q[pos_d]) begin
            ground_d   = 1'b0;
            fall_len_d = FALL_W'(HOLE_DEPTH);
            fall_cnt_d = '0;
            state_d    = ST_FALL;
          end
          // A splatted walker drives all outputs low; two such cycles mean death
          idle_d = ground && !(walk_left || walk_right || aaah);
          if (idle_d && idle_q) begin
            dead_d  = 1'b1;
            state_d = ST_DEAD;
          end
        end
        if (map_load) begin
          map_d        = map_in;
          map_d[pos_d] = 1'b1;
        end
      end

      ST_FALL: begin
        if (fall_cnt_q == fall_len_q - FALL_W'(1)) begin
          // Landing: the cell now holds the floor the lemming stands on
          ground_d   = 1'b1;
          map_d[pos] = 1'b1;
          fall_cnt_d = '0;
          state_d    = ST_WALK;
        end else begin
          fall_cnt_d = fall_cnt_q + FALL_W'(1);
        end
      end

      ST_DEAD: begin
        ground_d = 1'b1;
        if (map_load) begin
          map_d      = map_in;
          map_d[pos] = 1'b1;
        end
      end

      default: begin
        state_d = ST_WALK;
      end
    endcase

    // Dig is only forwarded while the lemming stays walking
    dig_d = dig_req && (state_q == ST_WALK) && (state_d == ST_WALK);
  end

  // State and output registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_WALK;
      map_q      <= '1;
      fall_cnt_q <= '0;
      fall_len_q <= '0;
      dig_cnt_q  <= '0;
      idle_q     <= 1'b0;
      pos        <= POS_W'(START_POS);
      ground     <= 1'b1;
      bump_left  <= 1'b0;
      bump_right <= 1'b0;
      dig        <= 1'b0;
      dead       <= 1'b0;
    end else begin
      state_q    <= state_d;
      map_q      <= map_d;
      fall_cnt_q <= fall_cnt_d;
      fall_len_q <= fall_len_d;
      dig_cnt_q  <= dig_cnt_d;
      idle_q     <= idle_d;
      pos        <= pos_d;
      ground     <= ground_d;
      bump_left  <= bump_l_d;
      bump_right <= bump_r_d;
      dig        <= dig_d;
      dead       <= dead_d;
    end
  end

endmodule
